// File: rtl/eth_rx_deframer.sv
// eth_rx_deframer
//   RMII receive deframer. Samples Crs_Dv/Rxd every Clk cycle, finds the
//   preamble and SFD, and packs dibits into bytes LSB-first. It emits a byte
//   stream with per-frame start, end and error qualifiers.
//
//   Optional feature macro: ETH_RX_CRC_CHECK_EN
//     When defined, a CRC-32 runs over every emitted byte, including the FCS.
//     A bad residue at end of frame sets Eth_Pkt_Err.
//
//   Ports
//     Clk            in   50 MHz RMII reference clock
//     Rst            in   synchronous, active-high reset
//     Crs_Dv         in   RMII carrier sense / data valid
//     Rxd[1:0]       in   RMII receive dibit
//     Eth_Byte[7:0]  out  assembled byte, qualified by Eth_Byte_Valid
//     Eth_Byte_Valid out  one-cycle pulse per byte
//     Eth_Pkt_Start  out  marks the first byte of a frame
//     Eth_Pkt_End    out  one-cycle pulse when the frame terminates
//     Eth_Pkt_Err    out  qualifies Eth_Pkt_End: frame is bad
//     Eth_Byte_Count out  bytes in current/last frame
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   IDLE     | waiting for the first preamble dibit (false carrier ignored)
//   PREAMBLE | counting 01 dibits, waiting for the 11 SFD dibit
//   DATA     | assembling bytes until carrier drops or oversize
//   DROP     | discarding the rest of the carrier event
module eth_rx_deframer #(
  parameter int MIN_PREAMBLE_DIBITS = 8,
  parameter int MIN_BYTES           = 64,
  parameter int MAX_BYTES           = 1522
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Crs_Dv,
  input  logic [1:0]  Rxd,
  output logic [7:0]  Eth_Byte,
  output logic        Eth_Byte_Valid,
  output logic        Eth_Pkt_Start,
  output logic        Eth_Pkt_End,
  output logic        Eth_Pkt_Err,
  output logic [15:0] Eth_Byte_Count
);

  localparam logic [4:0]  MIN_PRE = 5'(MIN_PREAMBLE_DIBITS);
  localparam logic [15:0] MIN_LEN = 16'(MIN_BYTES);
  localparam logic [15:0] MAX_LEN = 16'(MAX_BYTES);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t      state_q, state_d;
  logic [4:0]  pre_cnt_q, pre_cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [5:0]  shift_q, shift_d;
  // Set at SFD, cleared on the first byte. The count output keeps the last
  // frame's value until the new frame's first byte.
  logic        first_q, first_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;
  logic        start_q, start_d;
  logic        end_q, end_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  full_byte;
  logic        crc_bad;

`ifdef ETH_RX_CRC_CHECK_EN
  // The register is kept in reflected (LSB-first) form. In that form, the
  // good-frame residue 0xC704DD7B appears bit-reversed as 0xDEBB20E3.
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  logic [31:0] crc_q, crc_d;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign crc_bad = (crc_q != CRC_RESIDUE);
`else
  assign crc_bad = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    first_d   = first_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    start_d   = 1'b0;
    end_d     = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    full_byte = {Rxd, shift_q};
`ifdef ETH_RX_CRC_CHECK_EN
    crc_d     = crc_q;
`endif
    case (state_q)
      IDLE: begin
        if (Crs_Dv && Rxd == 2'b01) begin
          state_d   = PREAMBLE;
          pre_cnt_d = 5'd1;
        end
      end
      PREAMBLE: begin
        if (!Crs_Dv) begin
          state_d = IDLE;
        end else if (Rxd == 2'b01) begin
          if (pre_cnt_q != 5'd31) pre_cnt_d = pre_cnt_q + 5'd1;
        end else if (Rxd == 2'b11 && pre_cnt_q >= MIN_PRE) begin
          state_d = DATA;
          idx_d   = 2'd0;
          first_d = 1'b1;
        end else begin
          state_d = DROP;
        end
      end
      DATA: begin
        if (!Crs_Dv) begin
          // A frame with no complete byte is a runt regardless of the held count.
          state_d = IDLE;
          end_d   = 1'b1;
          err_d   = (idx_q != 2'd0) || first_q || (cnt_q < MIN_LEN) || crc_bad;
        end else if (idx_q != 2'd3) begin
          case (idx_q)
            2'd0:    shift_d[1:0] = Rxd;
            2'd1:    shift_d[3:2] = Rxd;
            default: shift_d[5:4] = Rxd;
          endcase
          idx_d = idx_q + 2'd1;
        end else begin
          idx_d = 2'd0;
          if (!first_q && cnt_q == MAX_LEN) begin
            state_d = DROP;
            end_d   = 1'b1;
            err_d   = 1'b1;
          end else begin
            valid_d = 1'b1;
            byte_d  = full_byte;
            start_d = first_q;
            first_d = 1'b0;
            if (first_q)              cnt_d = 16'd1;
            else if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`ifdef ETH_RX_CRC_CHECK_EN
            crc_d = crc_byte(first_q ? 32'hFFFFFFFF : crc_q, full_byte);
`endif
          end
        end
      end
      DROP: begin
        if (!Crs_Dv) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      pre_cnt_q <= 5'd0;
      idx_q     <= 2'd0;
      shift_q   <= 6'd0;
      first_q   <= 1'b0;
      byte_q    <= 8'd0;
      valid_q   <= 1'b0;
      start_q   <= 1'b0;
      end_q     <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= 16'd0;
`ifdef ETH_RX_CRC_CHECK_EN
      crc_q     <= 32'hFFFFFFFF;
`endif
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      first_q   <= first_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      start_q   <= start_d;
      end_q     <= end_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
`ifdef ETH_RX_CRC_CHECK_EN
      crc_q     <= crc_d;
`endif
    end
  end

  assign Eth_Byte       = byte_q;
  assign Eth_Byte_Valid = valid_q;
  assign Eth_Pkt_Start  = start_q;
  assign Eth_Pkt_End    = end_q;
  assign Eth_Pkt_Err    = err_q;
  assign Eth_Byte_Count = cnt_q;

endmodule

// File: tb/tb_eth_rx_deframer.sv
// Testbench for eth_rx_deframer: random and directed RMII frames.
// Each test is compared against a frame-level reference model.
module tb_eth_rx_deframer;

  localparam int MIN_PRE = 8;
  localparam int MIN_B   = 64;
  localparam int MAX_B   = 1522;

  typedef logic [7:0] bq_t[$];
  typedef struct {int len; int mode; bit inc; int pre; int extra;} scen_t;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Crs_Dv;
  logic [1:0]  Rxd;
  logic [7:0]  Eth_Byte;
  logic        Eth_Byte_Valid;
  logic        Eth_Pkt_Start;
  logic        Eth_Pkt_End;
  logic        Eth_Pkt_Err;
  logic [15:0] Eth_Byte_Count;

  int checks = 0;
  int errors = 0;
  int held_cnt = 0;

  eth_rx_deframer #(.MIN_PREAMBLE_DIBITS(MIN_PRE), .MIN_BYTES(MIN_B), .MAX_BYTES(MAX_B)) dut (
    .Clk(Clk), .Rst(Rst), .Crs_Dv(Crs_Dv), .Rxd(Rxd),
    .Eth_Byte(Eth_Byte), .Eth_Byte_Valid(Eth_Byte_Valid),
    .Eth_Pkt_Start(Eth_Pkt_Start), .Eth_Pkt_End(Eth_Pkt_End),
    .Eth_Pkt_Err(Eth_Pkt_Err), .Eth_Byte_Count(Eth_Byte_Count)
  );

  always #10 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Monitor: log every byte and every end-of-frame event.
  logic [7:0] rx_byte[$];
  bit         rx_start[$];
  int         rx_cnt[$];
  int         rx_cyc[$];
  bit         end_err[$];
  int         end_cnt[$];
  int         end_cyc[$];
  int         anomaly = 0;

  always @(negedge Clk) begin
    if (Eth_Byte_Valid === 1'b1) begin
      rx_byte.push_back(Eth_Byte);
      rx_start.push_back(Eth_Pkt_Start);
      rx_cnt.push_back(int'(Eth_Byte_Count));
      rx_cyc.push_back(cyc);
    end
    if (Eth_Pkt_End === 1'b1) begin
      end_err.push_back(Eth_Pkt_Err);
      end_cnt.push_back(int'(Eth_Byte_Count));
      end_cyc.push_back(cyc);
    end
    if ((Eth_Byte_Valid === 1'b1 && Eth_Pkt_End === 1'b1) ||
        (Eth_Pkt_Err === 1'b1 && Eth_Pkt_End !== 1'b1) ||
        (Eth_Pkt_Start === 1'b1 && Eth_Byte_Valid !== 1'b1))
      anomaly <= anomaly + 1;
  end

  // Reference: standard Ethernet FCS (reflected CRC-32 with final inversion).
  function automatic logic [31:0] crc32(input bq_t b, input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, b[i]};
      for (int j = 0; j < 8; j++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic bit fcs_ok(input bq_t f);
    int n;
    n = f.size();
    if (n < 5) return 1'b0;
    return crc32(f, n - 4) == {f[n-1], f[n-2], f[n-3], f[n-4]};
  endfunction

  // mode 0: payload + good FCS, 1: payload bit flipped after FCS, 2: raw bytes
  function automatic bq_t make_frame(input int len, input int mode, input bit inc);
    bq_t f;
    logic [31:0] fcs;
    int pl;
    int p;
    pl = (mode == 2) ? len : len - 4;
    for (int i = 0; i < pl; i++) f.push_back(inc ? 8'(i) : 8'($urandom));
    if (mode != 2) begin
      fcs = crc32(f, pl);
      for (int k = 0; k < 4; k++) f.push_back(fcs[8*k +: 8]);
      if (mode == 1) begin
        p = int'($urandom_range(0, pl - 1));
        f[p] = f[p] ^ (8'd1 << $urandom_range(0, 7));
      end
    end
    return f;
  endfunction

  task automatic drive(input logic cdv, input logic [1:0] d);
    Crs_Dv = cdv;
    Rxd    = d;
    @(posedge Clk);
    #1;
  endtask

  task automatic send_frame(input int pre, input logic [1:0] sfd, input bq_t f,
                            input int extra, input int fc);
    int r;
    logic [7:0] b;
    for (int i = 0; i < fc; i++) begin
      r = int'($urandom_range(0, 2));
      drive(1'b1, (r == 0) ? 2'b00 : (r == 1) ? 2'b10 : 2'b11);
    end
    for (int i = 0; i < pre; i++) drive(1'b1, 2'b01);
    drive(1'b1, sfd);
    for (int i = 0; i < f.size(); i++) begin
      b = f[i];
      for (int k = 0; k < 4; k++) drive(1'b1, b[2*k +: 2]);
    end
    for (int i = 0; i < extra; i++) drive(1'b1, 2'($urandom));
    repeat (6) drive(1'b0, 2'b00);
  endtask

  task automatic test_reset();
    Rst = 1'b1; Crs_Dv = 1'b1; Rxd = 2'b01;
    repeat (3) @(posedge Clk);
    #1;
    checks++; if (Eth_Byte !== 8'd0)         begin errors++; $display("FAIL reset Eth_Byte: got %h expected 00", Eth_Byte); end
    checks++; if (Eth_Byte_Valid !== 1'b0)   begin errors++; $display("FAIL reset Eth_Byte_Valid: got %b expected 0", Eth_Byte_Valid); end
    checks++; if (Eth_Pkt_Start !== 1'b0)    begin errors++; $display("FAIL reset Eth_Pkt_Start: got %b expected 0", Eth_Pkt_Start); end
    checks++; if (Eth_Pkt_End !== 1'b0)      begin errors++; $display("FAIL reset Eth_Pkt_End: got %b expected 0", Eth_Pkt_End); end
    checks++; if (Eth_Pkt_Err !== 1'b0)      begin errors++; $display("FAIL reset Eth_Pkt_Err: got %b expected 0", Eth_Pkt_Err); end
    checks++; if (Eth_Byte_Count !== 16'd0)  begin errors++; $display("FAIL reset Eth_Byte_Count: got %0d expected 0", Eth_Byte_Count); end
    Rst = 1'b0; Crs_Dv = 1'b0; Rxd = 2'b00;
    repeat (2) drive(1'b0, 2'b00);
    held_cnt = 0;
  endtask

  task automatic test_frames();
    scen_t tbl[$];
    scen_t s;
    bq_t f;
    int nb0, ne0, an0, exp_n, fc;
    bit drop, exp_err, crc_err;
    tbl.push_back('{64, 0, 1'b1, 15, 0});
    tbl.push_back('{64, 2, 1'b1, 15, 0});
    tbl.push_back('{64, 1, 1'b1, 15, 0});
    tbl.push_back('{70, 0, 1'b0, 15, 1});
    tbl.push_back('{63, 0, 1'b0, MIN_PRE, 0});
    tbl.push_back('{65, 0, 1'b0, MIN_PRE - 1, 0});
    tbl.push_back('{100, 0, 1'b0, 40, 0});
    tbl.push_back('{64, 0, 1'b0, 31, 2});
    tbl.push_back('{2, 2, 1'b0, 12, 0});
    for (int i = 0; i < 24; i++) begin
      s.len   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 63)) : int'($urandom_range(64, 140));
      s.mode  = ($urandom_range(0, 3) == 0) ? 1 : 0;
      s.inc   = 1'b0;
      s.pre   = int'($urandom_range(6, 36));
      s.extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      tbl.push_back(s);
    end
    foreach (tbl[t]) begin
      s = tbl[t];
      f = make_frame(s.len, s.mode, s.inc);
      nb0 = rx_byte.size(); ne0 = end_err.size(); an0 = anomaly;
      fc = int'($urandom_range(0, 3));
      drop = s.pre < MIN_PRE;
`ifdef ETH_RX_CRC_CHECK_EN
      crc_err = !fcs_ok(f);
`else
      crc_err = 1'b0;
`endif
      exp_n   = drop ? 0 : (s.len > MAX_B ? MAX_B : s.len);
      exp_err = (s.len > MAX_B) || (s.extra != 0) || (s.len < MIN_B) || crc_err;
      send_frame(s.pre, 2'b11, f, s.extra, fc);
      checks++;
      if (rx_byte.size() - nb0 !== exp_n) begin
        errors++; $display("FAIL frame%0d byte total: got %0d expected %0d", t, rx_byte.size() - nb0, exp_n);
      end
      for (int i = 0; i < exp_n; i++) begin
        if (nb0 + i >= rx_byte.size()) break;
        checks++;
        if (rx_byte[nb0+i] !== f[i] || rx_start[nb0+i] !== (i == 0) || rx_cnt[nb0+i] !== i + 1) begin
          errors++;
          $display("FAIL frame%0d byte%0d: got %h start %0b count %0d, expected %h start %0b count %0d",
                   t, i, rx_byte[nb0+i], rx_start[nb0+i], rx_cnt[nb0+i], f[i], (i == 0), i + 1);
        end
      end
      checks++;
      if (end_err.size() - ne0 !== (drop ? 0 : 1)) begin
        errors++; $display("FAIL frame%0d end pulses: got %0d expected %0d", t, end_err.size() - ne0, drop ? 0 : 1);
      end else if (!drop) begin
        checks++;
        if (end_err[ne0] !== exp_err) begin
          errors++; $display("FAIL frame%0d Eth_Pkt_Err: got %0b expected %0b", t, end_err[ne0], exp_err);
        end
        checks++;
        if (end_cnt[ne0] !== exp_n) begin
          errors++; $display("FAIL frame%0d end count: got %0d expected %0d", t, end_cnt[ne0], exp_n);
        end
        if (exp_n > 0 && rx_byte.size() - nb0 == exp_n) begin
          checks++;
          if (end_cyc[ne0] - rx_cyc[rx_cyc.size()-1] !== s.extra + 1) begin
            errors++; $display("FAIL frame%0d end latency: got %0d expected %0d", t,
                               end_cyc[ne0] - rx_cyc[rx_cyc.size()-1], s.extra + 1);
          end
        end
      end
      if (!drop) held_cnt = exp_n;
      checks++;
      if (int'(Eth_Byte_Count) !== held_cnt) begin
        errors++; $display("FAIL frame%0d held count: got %0d expected %0d", t, Eth_Byte_Count, held_cnt);
      end
      checks++;
      if (anomaly !== an0) begin
        errors++; $display("FAIL frame%0d framing anomalies: got %0d expected 0", t, anomaly - an0);
      end
    end
  endtask

  task automatic test_short_preamble();
    bq_t f;
    int nb0, ne0;
    for (int sc = 0; sc < 4; sc++) begin
      f = make_frame(20, 2, 1'b0);
      nb0 = rx_byte.size(); ne0 = end_err.size();
      case (sc)
        0: send_frame(4, 2'b11, f, 0, 0);
        1: send_frame(10, 2'b10, f, 0, 0);
        2: send_frame(10, 2'b00, f, 0, 0);
        default: begin
          repeat (12) drive(1'b1, 2'b01);
          repeat (6) drive(1'b0, 2'b00);
        end
      endcase
      checks++;
      if (rx_byte.size() !== nb0 || end_err.size() !== ne0) begin
        errors++; $display("FAIL short_preamble%0d outputs: got %0d bytes %0d ends expected 0 0",
                           sc, rx_byte.size() - nb0, end_err.size() - ne0);
      end
      checks++;
      if (int'(Eth_Byte_Count) !== held_cnt) begin
        errors++; $display("FAIL short_preamble%0d held count: got %0d expected %0d", sc, Eth_Byte_Count, held_cnt);
      end
    end
  endtask

  task automatic test_oversize();
    bq_t f;
    int nb0, ne0, nbad;
    f = make_frame(1600, 2, 1'b0);
    nb0 = rx_byte.size(); ne0 = end_err.size();
    send_frame(15, 2'b11, f, 0, 0);
    checks++;
    if (rx_byte.size() - nb0 !== MAX_B) begin
      errors++; $display("FAIL oversize byte total: got %0d expected %0d", rx_byte.size() - nb0, MAX_B);
    end
    nbad = 0;
    for (int i = 0; i < MAX_B && nb0 + i < rx_byte.size(); i++)
      if (rx_byte[nb0+i] !== f[i] || rx_cnt[nb0+i] !== i + 1 || rx_start[nb0+i] !== (i == 0)) nbad++;
    checks++;
    if (nbad !== 0) begin
      errors++; $display("FAIL oversize byte contents: got %0d wrong bytes expected 0", nbad);
    end
    checks++;
    if (end_err.size() - ne0 !== 1) begin
      errors++; $display("FAIL oversize end pulses: got %0d expected 1", end_err.size() - ne0);
    end else begin
      checks++;
      if (end_err[ne0] !== 1'b1 || end_cnt[ne0] !== MAX_B) begin
        errors++; $display("FAIL oversize end: got err %0b count %0d expected err 1 count %0d",
                           end_err[ne0], end_cnt[ne0], MAX_B);
      end
      checks++;
      if (rx_byte.size() - nb0 == MAX_B && end_cyc[ne0] - rx_cyc[rx_cyc.size()-1] !== 4) begin
        errors++; $display("FAIL oversize end position: got %0d expected 4",
                           end_cyc[ne0] - rx_cyc[rx_cyc.size()-1]);
      end
    end
    held_cnt = MAX_B;
    checks++;
    if (int'(Eth_Byte_Count) !== held_cnt) begin
      errors++; $display("FAIL oversize held count: got %0d expected %0d", Eth_Byte_Count, held_cnt);
    end
  endtask

  task automatic test_reset_mid_frame();
    bq_t f;
    logic [7:0] b;
    int nb0, ne0;
    for (int i = 0; i < 10; i++) f.push_back(8'($urandom_range(1, 255)));
    nb0 = rx_byte.size(); ne0 = end_err.size();
    repeat (15) drive(1'b1, 2'b01);
    drive(1'b1, 2'b11);
    for (int i = 0; i < 10; i++) begin
      b = f[i];
      for (int k = 0; k < 4; k++) drive(1'b1, b[2*k +: 2]);
    end
    Rst = 1'b1; Crs_Dv = 1'b1; Rxd = 2'b00;
    @(posedge Clk);
    #1;
    checks++; if (Eth_Byte !== 8'd0)        begin errors++; $display("FAIL midreset Eth_Byte: got %h expected 00", Eth_Byte); end
    checks++; if (Eth_Byte_Valid !== 1'b0)  begin errors++; $display("FAIL midreset Eth_Byte_Valid: got %b expected 0", Eth_Byte_Valid); end
    checks++; if (Eth_Pkt_End !== 1'b0)     begin errors++; $display("FAIL midreset Eth_Pkt_End: got %b expected 0", Eth_Pkt_End); end
    checks++; if (Eth_Byte_Count !== 16'd0) begin errors++; $display("FAIL midreset Eth_Byte_Count: got %0d expected 0", Eth_Byte_Count); end
    Rst = 1'b0;
    repeat (20) drive(1'b1, 2'b00);
    repeat (6) drive(1'b0, 2'b00);
    held_cnt = 0;
    checks++;
    if (rx_byte.size() - nb0 !== 10 || end_err.size() !== ne0) begin
      errors++; $display("FAIL midreset outputs: got %0d bytes %0d ends expected 10 0",
                         rx_byte.size() - nb0, end_err.size() - ne0);
    end
    checks++;
    if (rx_byte.size() - nb0 == 10 && (rx_byte[nb0] !== f[0] || rx_byte[nb0+9] !== f[9])) begin
      errors++; $display("FAIL midreset bytes: got %h..%h expected %h..%h", rx_byte[nb0], rx_byte[nb0+9], f[0], f[9]);
    end
    f = make_frame(64, 0, 1'b0);
    nb0 = rx_byte.size(); ne0 = end_err.size();
    send_frame(15, 2'b11, f, 0, 0);
    checks++;
    if (rx_byte.size() - nb0 !== 64 || end_err.size() - ne0 !== 1) begin
      errors++; $display("FAIL postreset frame: got %0d bytes %0d ends expected 64 1",
                         rx_byte.size() - nb0, end_err.size() - ne0);
    end else begin
      checks++;
      if (end_err[ne0] !== 1'b0 || end_cnt[ne0] !== 64 || rx_byte[nb0+63] !== f[63]) begin
        errors++; $display("FAIL postreset end: got err %0b count %0d last %h expected err 0 count 64 last %h",
                           end_err[ne0], end_cnt[ne0], rx_byte[nb0+63], f[63]);
      end
    end
    held_cnt = 64;
    checks++;
    if (int'(Eth_Byte_Count) !== 64) begin
      errors++; $display("FAIL postreset held count: got %0d expected 64", Eth_Byte_Count);
    end
  endtask

  initial begin
    Rst = 1'b1; Crs_Dv = 1'b0; Rxd = 2'b00;
    test_reset();
    test_frames();
    test_short_preamble();
    test_oversize();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
